// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
// Forwarding-select encodings and the mul/div tracker state type.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] Rs_D, Rt_D, Rs_E, Rt_E;
    logic [REG_AW-1:0] Write_Reg_E, Write_Reg_M, Write_Reg_W;
    logic              Reg_Write_E, Reg_Write_M, Reg_Write_W;
    logic              MemtoReg_E, MemtoReg_M;
    logic              Branch_D, Branch_Taken;
    logic              MD_Start_E, MD_Use_D;
    logic              Stall_F, Stall_D, Flush_D, Flush_E;
    logic              Forward_A_D, Forward_B_D;
    logic [1:0]        Forward_A_E, Forward_B_E;
    logic              MD_Busy;
    logic [CNT_W-1:0]  Stall_Count, Flush_Count;

    modport master (
        output Rs_D, Rt_D, Rs_E, Rt_E,
        output Write_Reg_E, Write_Reg_M, Write_Reg_W,
        output Reg_Write_E, Reg_Write_M, Reg_Write_W,
        output MemtoReg_E, MemtoReg_M,
        output Branch_D, Branch_Taken, MD_Start_E, MD_Use_D,
        input  Stall_F, Stall_D, Flush_D, Flush_E,
        input  Forward_A_D, Forward_B_D, Forward_A_E, Forward_B_E,
        input  MD_Busy, Stall_Count, Flush_Count
    );

    modport slave (
        input  Rs_D, Rt_D, Rs_E, Rt_E,
        input  Write_Reg_E, Write_Reg_M, Write_Reg_W,
        input  Reg_Write_E, Reg_Write_M, Reg_Write_W,
        input  MemtoReg_E, MemtoReg_M,
        input  Branch_D, Branch_Taken, MD_Start_E, MD_Use_D,
        output Stall_F, Stall_D, Flush_D, Flush_E,
        output Forward_A_D, Forward_B_D, Forward_A_E, Forward_B_E,
        output MD_Busy, Stall_Count, Flush_Count
    );
endinterface

// File: rtl/md_busy_tracker.sv
// Multi-cycle mul/div occupancy tracker: busy for MD_LAT-1 cycles after start.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    output logic md_busy
);
    localparam int CW = ($clog2(MD_LAT) < 4) ? 4 : $clog2(MD_LAT);

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    state_d = MD_BUSY;
                    cnt_d   = CW'(MD_LAT - 1);
                end
            end
            MD_BUSY: begin
                // a start while busy is ignored; the unit is non-pipelined
                if (cnt_q == CW'(1)) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection, forwarding selects and stall/flush statistics
// for the 5-stage MIPS pipeline.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MD_LAT      = 8,
    parameter int CNT_W       = 16,
    parameter int BRANCH_IN_D = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam logic BR_D = (BRANCH_IN_D != 0);

    function automatic logic hit(input logic [REG_AW-1:0] a,
                                 input logic [REG_AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    logic             md_busy;
    logic             lwstall, brstall, mdstall, stall;
    logic             stall_f, flush_d, flush_e;
    logic             fwd_a_d, fwd_b_d;
    logic [1:0]       fwd_a_e, fwd_b_e;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    md_busy_tracker #(.MD_LAT(MD_LAT)) u_md (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (hz.MD_Start_E),
        .md_busy  (md_busy)
    );

    always_comb begin
        fwd_a_e = FWD_RF;
        if (hz.Reg_Write_M && hit(hz.Write_Reg_M, hz.Rs_E))
            fwd_a_e = FWD_M;
        else if (hz.Reg_Write_W && hit(hz.Write_Reg_W, hz.Rs_E))
            fwd_a_e = FWD_W;
        fwd_b_e = FWD_RF;
        if (hz.Reg_Write_M && hit(hz.Write_Reg_M, hz.Rt_E))
            fwd_b_e = FWD_M;
        else if (hz.Reg_Write_W && hit(hz.Write_Reg_W, hz.Rt_E))
            fwd_b_e = FWD_W;
        fwd_a_d = BR_D && hz.Reg_Write_M && hit(hz.Write_Reg_M, hz.Rs_D);
        fwd_b_d = BR_D && hz.Reg_Write_M && hit(hz.Write_Reg_M, hz.Rt_D);
    end

    always_comb begin
        lwstall = hz.MemtoReg_E &&
                  (hit(hz.Rt_E, hz.Rs_D) || hit(hz.Rt_E, hz.Rt_D));
        brstall = BR_D && hz.Branch_D &&
                  ((hz.Reg_Write_E &&
                    (hit(hz.Write_Reg_E, hz.Rs_D) ||
                     hit(hz.Write_Reg_E, hz.Rt_D))) ||
                   (hz.MemtoReg_M &&
                    (hit(hz.Write_Reg_M, hz.Rs_D) ||
                     hit(hz.Write_Reg_M, hz.Rt_D))));
        mdstall = hz.MD_Use_D && (md_busy || hz.MD_Start_E);
        stall   = lwstall || brstall || mdstall;
        // an E-resolved taken branch squashes D, so D never stalls
        if (!BR_D && hz.Branch_Taken) begin
            stall_f = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            stall_f = stall;
            flush_e = stall;
            flush_d = BR_D && hz.Branch_Taken && !stall;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_d && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.Stall_F     = rst_n && stall_f;
    assign hz.Stall_D     = rst_n && stall_f;
    assign hz.Flush_D     = !rst_n || flush_d;
    assign hz.Flush_E     = !rst_n || flush_e;
    assign hz.Forward_A_E = rst_n ? fwd_a_e : FWD_RF;
    assign hz.Forward_B_E = rst_n ? fwd_b_e : FWD_RF;
    assign hz.Forward_A_D = rst_n && fwd_a_d;
    assign hz.Forward_B_D = rst_n && fwd_b_d;
    assign hz.MD_Busy     = md_busy;
    assign hz.Stall_Count = stall_cnt_q;
    assign hz.Flush_Count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: D-resolved instance with default widths and an
// E-resolved instance with 4-bit counters for saturation.
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) hz1 ();
    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  hz0 ();

    pipeline_hazard_ctrl #(
        .REG_AW(5), .MD_LAT(8), .CNT_W(16), .BRANCH_IN_D(1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz1.slave)
    );

    pipeline_hazard_ctrl #(
        .REG_AW(5), .MD_LAT(8), .CNT_W(4), .BRANCH_IN_D(0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz0.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hz1.Rs_D = '0; hz1.Rt_D = '0; hz1.Rs_E = '0; hz1.Rt_E = '0;
        hz1.Write_Reg_E = '0; hz1.Write_Reg_M = '0; hz1.Write_Reg_W = '0;
        hz1.Reg_Write_E = 0; hz1.Reg_Write_M = 0; hz1.Reg_Write_W = 0;
        hz1.MemtoReg_E = 0; hz1.MemtoReg_M = 0;
        hz1.Branch_D = 0; hz1.Branch_Taken = 0;
        hz1.MD_Start_E = 0; hz1.MD_Use_D = 0;
        hz0.Rs_D = '0; hz0.Rt_D = '0; hz0.Rs_E = '0; hz0.Rt_E = '0;
        hz0.Write_Reg_E = '0; hz0.Write_Reg_M = '0; hz0.Write_Reg_W = '0;
        hz0.Reg_Write_E = 0; hz0.Reg_Write_M = 0; hz0.Reg_Write_W = 0;
        hz0.MemtoReg_E = 0; hz0.MemtoReg_M = 0;
        hz0.Branch_D = 0; hz0.Branch_Taken = 0;
        hz0.MD_Start_E = 0; hz0.MD_Use_D = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clr();
        hz1.Reg_Write_M = 1; hz1.Write_Reg_M = 3; hz1.Rs_E = 3;
        #2;
        chk("rst_stall_f", hz1.Stall_F, 0);
        chk("rst_flush_d", hz1.Flush_D, 1);
        chk("rst_flush_e", hz1.Flush_E, 1);
        chk("rst_fwd_a_e", hz1.Forward_A_E, 0);
        chk("rst_md_busy", hz1.MD_Busy, 0);
        chk("rst_stall_cnt", hz1.Stall_Count, 0);
        chk("rst_m0_flush_d", hz0.Flush_D, 1);
        #10 rst_n = 1'b1;

        step();
        chk("fwd_m", hz1.Forward_A_E, 2);
        chk("fwd_b_rf", hz1.Forward_B_E, 0);
        chk("idle_flush_e", hz1.Flush_E, 0);
        hz1.Reg_Write_W = 1; hz1.Write_Reg_W = 3;
        #1 chk("fwd_m_prio", hz1.Forward_A_E, 2);
        hz1.Reg_Write_M = 0;
        #1 chk("fwd_w", hz1.Forward_A_E, 1);
        hz1.Rt_E = 3;
        #1 chk("fwd_b_w", hz1.Forward_B_E, 1);
        hz1.Write_Reg_W = 0; hz1.Rs_E = 0;
        #1 chk("fwd_zero", hz1.Forward_A_E, 0);

        clr();
        hz1.MemtoReg_E = 1; hz1.Rt_E = 5; hz1.Rs_D = 5;
        #1;
        chk("lw_stall_f", hz1.Stall_F, 1);
        chk("lw_stall_d", hz1.Stall_D, 1);
        chk("lw_flush_e", hz1.Flush_E, 1);
        chk("lw_flush_d", hz1.Flush_D, 0);
        step();
        hz1.Rt_E = 0; hz1.Rs_D = 0;
        #1;
        chk("lw_zero_nostall", hz1.Stall_D, 0);
        chk("stall_cnt_1", hz1.Stall_Count, 1);

        clr();
        hz1.Reg_Write_M = 1; hz1.Write_Reg_M = 9;
        hz1.Rs_D = 9; hz1.Rt_D = 9;
        hz0.Reg_Write_M = 1; hz0.Write_Reg_M = 9; hz0.Rs_D = 9;
        #1;
        chk("fwd_a_d", hz1.Forward_A_D, 1);
        chk("fwd_b_d", hz1.Forward_B_D, 1);
        chk("m0_fwd_a_d", hz0.Forward_A_D, 0);

        clr();
        hz1.Branch_D = 1; hz1.Reg_Write_E = 1; hz1.Write_Reg_E = 7;
        hz1.Rt_D = 7; hz1.Branch_Taken = 1;
        #1;
        chk("br_stall", hz1.Stall_D, 1);
        chk("br_stall_flush_d", hz1.Flush_D, 0);
        chk("br_stall_flush_e", hz1.Flush_E, 1);
        step();
        hz1.Reg_Write_E = 0;
        #1;
        chk("br_taken_flush_d", hz1.Flush_D, 1);
        chk("br_taken_nostall", hz1.Stall_F, 0);
        step();
        chk("stall_cnt_2", hz1.Stall_Count, 2);
        chk("flush_cnt_1", hz1.Flush_Count, 1);
        clr();
        hz1.Branch_D = 1; hz1.MemtoReg_M = 1;
        hz1.Write_Reg_M = 4; hz1.Rs_D = 4;
        #1 chk("br_load_stall", hz1.Stall_D, 1);
        step();
        clr();
        #1 chk("stall_cnt_3", hz1.Stall_Count, 3);

        hz1.MD_Start_E = 1; hz1.MD_Use_D = 1;
        #1;
        chk("md_t_stall", hz1.Stall_D, 1);
        chk("md_t_busy", hz1.MD_Busy, 0);
        step();
        hz1.MD_Start_E = 0;
        #1;
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("md_busy_t%0d", k), hz1.MD_Busy, 1);
            chk($sformatf("md_stall_t%0d", k), hz1.Stall_D, 1);
            step();
        end
        chk("md_release_busy", hz1.MD_Busy, 0);
        chk("md_release_stall", hz1.Stall_D, 0);
        chk("stall_cnt_11", hz1.Stall_Count, 11);

        clr();
        hz1.MD_Start_E = 1;
        step();
        hz1.MD_Start_E = 0;
        step();
        step();
        step();
        #1 chk("md_busy_cnt4", hz1.MD_Busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", hz1.MD_Busy, 0);
        chk("rst_mid_scnt", hz1.Stall_Count, 0);
        chk("rst_mid_fcnt", hz1.Flush_Count, 0);
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_idle", hz1.MD_Busy, 0);
        hz1.MD_Use_D = 1;
        #1 chk("post_rst_nostall", hz1.Stall_D, 0);

        clr();
        hz0.Branch_Taken = 1; hz0.MemtoReg_E = 1;
        hz0.Rt_E = 5; hz0.Rs_D = 5;
        #1;
        chk("m0_flush_d", hz0.Flush_D, 1);
        chk("m0_flush_e", hz0.Flush_E, 1);
        chk("m0_stall_f", hz0.Stall_F, 0);
        chk("m0_stall_d", hz0.Stall_D, 0);
        step();
        hz0.Branch_Taken = 0;
        #1;
        chk("m0_flush_cnt", hz0.Flush_Count, 1);
        chk("m0_lw_stall", hz0.Stall_F, 1);
        chk("m0_lw_flush_e", hz0.Flush_E, 1);
        chk("m0_lw_flush_d", hz0.Flush_D, 0);
        hz0.MemtoReg_E = 0; hz0.Branch_D = 1;
        hz0.Reg_Write_E = 1; hz0.Write_Reg_E = 5;
        #1 chk("m0_no_br_stall", hz0.Stall_D, 0);
        hz0.MemtoReg_E = 1;
        repeat (19) step();
        chk("m0_stall_sat", hz0.Stall_Count, 15);
        chk("m0_flush_hold", hz0.Flush_Count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
